mu0_control: RTL and testbench
==============================

MU0_CONTROL -- requirements
Module: mu0_control

Interface
REQ-001 Parameters: none; all widths fixed by the 16-bit MU0 datapath.
REQ-002 Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 F  input  4  opcode, IR[15:12].
REQ-005 N  input  1  accumulator negative flag.
REQ-006 Z  input  1  accumulator zero flag.
REQ-007 MemReady  input  1  memory completes the current access this cycle when high.
REQ-008 X_sel  output  1  ALU A-operand mux select: 0 = ACC, 1 = PC.
REQ-009 Y_sel  output  1  ALU B-operand mux select: 0 = memory data, 1 = IR.
REQ-010 Addr_sel  output  1  address mux select: 0 = PC, 1 = IR[11:0].
REQ-011 PC_En, IR_En, Acc_En  output  1 each  register load enables.
REQ-012 ALU_FS  output  2  ALU function: 00 = B, 01 = A+B, 10 = A+1, 11 = A-B.
REQ-013 MEMrq  output  1  memory request; RnW  output  1  1 = read, 0 = write.
REQ-014 Halted  output  1  processor stopped.

Function
REQ-015 The block SHALL hold a state register with the states FETCH, EXEC and HALT. Outputs SHALL be a combinational decode of state, F, N, Z and MemReady.
REQ-016 In FETCH the block SHALL drive Addr_sel=0, MEMrq=1, RnW=1, X_sel=1 and ALU_FS=10. When MemReady=1 it SHALL drive IR_En=1 and PC_En=1, and the next state SHALL be EXEC.
REQ-017 In EXEC, F=0 (LDA) SHALL drive Addr_sel=1, MEMrq=1, RnW=1, Y_sel=0, ALU_FS=00 and Acc_En=MemReady.
REQ-018 In EXEC, F=1 (STA) SHALL drive Addr_sel=1, MEMrq=1 and RnW=0, with no register enables.
REQ-019 In EXEC, F=2 (ADD) and F=3 (SUB) SHALL drive Addr_sel=1, MEMrq=1, RnW=1, X_sel=0, Y_sel=0, ALU_FS=01 or 11 respectively, and Acc_En=MemReady.
REQ-020 In EXEC, F=4 (JMP) SHALL drive Y_sel=1, ALU_FS=00, PC_En=1 and MEMrq=0.
REQ-021 F=5 (JGE) SHALL behave as JMP with PC_En=~N. F=6 (JNE) SHALL behave as JMP with PC_En=~Z.
REQ-022 In EXEC, F=7 (STP) SHALL drive no enables and MEMrq=0, and the next state SHALL be HALT.
REQ-023 F=8..15 SHALL execute as a 1-cycle NOP: no enables, MEMrq=0, next state FETCH.
REQ-024 Memory-accessing states (FETCH; EXEC with F=0..3) SHALL hold the current state while MemReady=0. During the hold, MEMrq, RnW and all selects SHALL stay stable and PC_En, IR_En and Acc_En SHALL be 0.
REQ-025 Non-memory EXEC (F=4..15) SHALL ignore MemReady and complete in exactly 1 cycle.
REQ-026 Completion of any EXEC other than STP SHALL move the next state to FETCH.
REQ-027 Latency with zero wait states: 2 cycles per instruction; each MemReady=0 cycle adds exactly 1 cycle.
REQ-028 HALT SHALL be absorbing: Halted=1, all enables 0, MEMrq=0, and only Reset leaves it.
REQ-029 Unused selects SHALL be driven 0. MEMrq=0 SHALL imply RnW=1.
REQ-030 At most one of PC_En, IR_En and Acc_En SHALL be asserted in EXEC. PC_En and IR_En together SHALL occur only in FETCH.

Reset
REQ-031 With Reset=1 at a rising edge, the next state SHALL be FETCH regardless of current state, including EXEC mid-wait and HALT.
REQ-032 While Reset=1, the block SHALL force PC_En=IR_En=Acc_En=0, MEMrq=0, RnW=1 and Halted=0, overriding the decode.
REQ-033 The first cycle after Reset deasserts SHALL be FETCH with the REQ-016 outputs.

Verification
REQ-034 Reset, then MemReady=1 held, F=0 -> cycle 1 FETCH: IR_En=PC_En=1, ALU_FS=10; cycle 2 EXEC: Addr_sel=1, Acc_En=1, ALU_FS=00; cycle 3 FETCH.
REQ-035 F=3, MemReady=0 for 2 cycles in EXEC then 1 -> EXEC held 3 cycles with Acc_En=0,0,1, ALU_FS=11 and MEMrq=1 throughout; FETCH follows.
REQ-036 F=5 with N=1, then F=5 with N=0; F=6 with Z=1, then F=6 with Z=0 -> PC_En=0,1,0,1 in the respective EXEC cycles, MEMrq=0 in each.
REQ-037 F=7 -> HALT entered after EXEC, Halted=1 for 10+ cycles with MEMrq=0 regardless of MemReady; Reset pulse -> FETCH, Halted=0.
REQ-038 Reset asserted during FETCH wait (MemReady=0) -> same cycle: IR_En=0, MEMrq=0; next cycle: FETCH with the REQ-016 outputs.
REQ-039 F=1, then F=12 -> STA EXEC: RnW=0, MEMrq=1, no enables; F=12 EXEC: 1 cycle, MEMrq=0, no enables, back to FETCH.

Source files
------------

// File: rtl/mu0_control.sv
// MU0 control unit: three-state sequencer (fetch / execute / halt) with a
// combinational decode of state, opcode, flags and memory handshake.
module mu0_control (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  input  logic       MemReady,
  output logic       X_sel,
  output logic       Y_sel,
  output logic       Addr_sel,
  output logic       PC_En,
  output logic       IR_En,
  output logic       Acc_En,
  output logic [1:0] ALU_FS,
  output logic       MEMrq,
  output logic       RnW,
  output logic       Halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [1:0] FS_B    = 2'b00;
  localparam logic [1:0] FS_ADD  = 2'b01;
  localparam logic [1:0] FS_INC  = 2'b10;
  localparam logic [1:0] FS_SUB  = 2'b11;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  state_t state_q;
  state_t state_d;

  // Output decode and next-state selection; reset overrides enables and memory request.
  always_comb begin
    state_d  = state_q;
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    Addr_sel = 1'b0;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Acc_En   = 1'b0;
    ALU_FS   = FS_B;
    MEMrq    = 1'b0;
    RnW      = 1'b1;
    Halted   = 1'b0;

    unique case (state_q)
      FETCH: begin
        Addr_sel = 1'b0;
        MEMrq    = 1'b1;
        X_sel    = 1'b1;
        ALU_FS   = FS_INC;
        IR_En    = MemReady;
        PC_En    = MemReady;
        if (MemReady) state_d = EXEC;
      end

      EXEC: begin
        state_d = FETCH;
        unique case (F)
          OP_LDA: begin
            Addr_sel = 1'b1;
            MEMrq    = 1'b1;
            ALU_FS   = FS_B;
            Acc_En   = MemReady;
            if (!MemReady) state_d = EXEC;
          end
          OP_STA: begin
            Addr_sel = 1'b1;
            MEMrq    = 1'b1;
            RnW      = 1'b0;
            if (!MemReady) state_d = EXEC;
          end
          OP_ADD, OP_SUB: begin
            Addr_sel = 1'b1;
            MEMrq    = 1'b1;
            ALU_FS   = (F == OP_ADD) ? FS_ADD : FS_SUB;
            Acc_En   = MemReady;
            if (!MemReady) state_d = EXEC;
          end
          OP_JMP: begin
            Y_sel = 1'b1;
            PC_En = 1'b1;
          end
          OP_JGE: begin
            Y_sel = 1'b1;
            PC_En = ~N;
          end
          OP_JNE: begin
            Y_sel = 1'b1;
            PC_En = ~Z;
          end
          OP_STP: begin
            state_d = HALT;
          end
          default: begin
            state_d = FETCH;
          end
        endcase
      end

      HALT: begin
        Halted  = 1'b1;
        state_d = HALT;
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    if (Reset) begin
      PC_En   = 1'b0;
      IR_En   = 1'b0;
      Acc_En  = 1'b0;
      MEMrq   = 1'b0;
      RnW     = 1'b1;
      Halted  = 1'b0;
      state_d = FETCH;
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    state_q <= state_d;
  end

endmodule

// File: tb/tb_mu0_control.sv
// Bench for mu0_control: directed instruction scenarios followed by random
// traffic, every cycle compared against an instruction-level reference model.
module tb_mu0_control;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] F;
  logic       N, Z, MemReady;
  logic       X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En;
  logic [1:0] ALU_FS;
  logic       MEMrq, RnW, Halted;

  int n_checks = 0;
  int n_errors = 0;

  // model phase: 0 = fetching, 1 = executing, 2 = stopped
  int m_phase = 0;

  always #5 Clk = ~Clk;

  mu0_control dut (
    .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .MemReady(MemReady),
    .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel),
    .PC_En(PC_En), .IR_En(IR_En), .Acc_En(Acc_En), .ALU_FS(ALU_FS),
    .MEMrq(MEMrq), .RnW(RnW), .Halted(Halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got[10:0], exp[10:0], $time);
    end
  endtask

  // Expected output bundle {X,Y,Addr,PC_En,IR_En,Acc_En,FS[1:0],MEMrq,RnW,Halted}
  // derived from what each instruction needs from the datapath.
  function automatic logic [10:0] ref_out(input int phase, input logic [3:0] f,
                                          input logic n, input logic z,
                                          input logic mr, input logic rst);
    logic x, y, a, pc, ir, acc, mq, rnw, h;
    logic [1:0] fs;
    bit mem_op, jump;
    x = 0; y = 0; a = 0; pc = 0; ir = 0; acc = 0; mq = 0; rnw = 1; h = 0; fs = 2'b00;
    mem_op = (f < 4);
    jump   = (f >= 4 && f <= 6);
    if (phase == 0) begin
      x = 1; fs = 2'b10; mq = 1; pc = mr; ir = mr;
    end else if (phase == 1) begin
      if (mem_op) begin
        a   = 1;
        mq  = 1;
        rnw = (f != 1);
        acc = (f != 1) && mr;
        if (f == 2) fs = 2'b01;
        if (f == 3) fs = 2'b11;
      end else if (jump) begin
        y  = 1;
        pc = (f == 4) ? 1'b1 : (f == 5) ? !n : !z;
      end
    end else begin
      h = 1;
    end
    if (rst) begin
      pc = 0; ir = 0; acc = 0; mq = 0; rnw = 1; h = 0;
    end
    return {x, y, a, pc, ir, acc, fs, mq, rnw, h};
  endfunction

  function automatic int ref_next(input int phase, input logic [3:0] f,
                                  input logic mr, input logic rst);
    if (rst) return 0;
    if (phase == 0) return mr ? 1 : 0;
    if (phase == 2) return 2;
    if (f < 4 && !mr) return 1;
    return (f == 7) ? 2 : 0;
  endfunction

  // One clock: drive on the falling edge, compare shortly after, advance model.
  task automatic cycle(input string tag, input logic [3:0] f, input logic n,
                       input logic z, input logic mr, input logic rst);
    logic [10:0] got;
    @(negedge Clk);
    F = f; N = n; Z = z; MemReady = mr; Reset = rst;
    #1;
    got = {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, ALU_FS, MEMrq, RnW, Halted};
    check(tag, {21'd0, got}, {21'd0, ref_out(m_phase, f, n, z, mr, rst)});
    if (!MEMrq) check({tag, "_rnw_idle"}, {31'd0, RnW}, 32'd1);
    m_phase = ref_next(m_phase, f, mr, rst);
  endtask

  logic [3:0] cur_f;
  logic       rmr, rrst;
  int halt_cycles;

  initial begin
    F = '0; N = 0; Z = 0; MemReady = 0; Reset = 1;
    @(posedge Clk);
    m_phase = 0;
    cycle("reset", 4'd0, 0, 0, 1, 1);

    // LDA, no wait states
    cycle("lda_fetch", 4'd0, 0, 0, 1, 0);
    cycle("lda_exec",  4'd0, 0, 0, 1, 0);
    // SUB with two wait states in execute
    cycle("sub_fetch", 4'd3, 0, 0, 1, 0);
    cycle("sub_wait0", 4'd3, 0, 0, 0, 0);
    cycle("sub_wait1", 4'd3, 0, 0, 0, 0);
    cycle("sub_exec",  4'd3, 0, 0, 1, 0);
    // conditional jumps
    cycle("jge_n1_f", 4'd5, 1, 0, 1, 0);
    cycle("jge_n1_e", 4'd5, 1, 0, 1, 0);
    cycle("jge_n0_f", 4'd5, 0, 0, 1, 0);
    cycle("jge_n0_e", 4'd5, 0, 0, 0, 0);
    cycle("jne_z1_f", 4'd6, 0, 1, 1, 0);
    cycle("jne_z1_e", 4'd6, 0, 1, 1, 0);
    cycle("jne_z0_f", 4'd6, 0, 0, 1, 0);
    cycle("jne_z0_e", 4'd6, 0, 0, 1, 0);
    // STA then an undefined opcode as NOP
    cycle("sta_fetch", 4'd1, 0, 0, 1, 0);
    cycle("sta_exec",  4'd1, 0, 0, 1, 0);
    cycle("nop_fetch", 4'd12, 0, 0, 1, 0);
    cycle("nop_exec",  4'd12, 0, 0, 0, 0);
    // reset during a stalled fetch
    cycle("fwait",     4'd2, 0, 0, 0, 0);
    cycle("fwait_rst", 4'd2, 0, 0, 0, 1);
    cycle("post_rst",  4'd2, 0, 0, 1, 0);
    cycle("add_exec",  4'd2, 0, 0, 1, 0);
    // STP and the absorbing halt
    cycle("stp_fetch", 4'd7, 0, 0, 1, 0);
    cycle("stp_exec",  4'd7, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cycle("halted", 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
      check("halted_flag", {31'd0, Halted}, 32'd1);
    end
    cycle("halt_rst",  4'd0, 0, 0, 1, 1);
    cycle("halt_exit", 4'd0, 0, 0, 1, 0);
    check("halt_cleared", {31'd0, Halted}, 32'd0);

    // random traffic; the opcode only changes while fetching, as from a real IR
    cur_f = 4'($urandom);
    halt_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_phase == 0) cur_f = 4'($urandom);
      rmr  = ($urandom_range(0, 3) != 0);
      rrst = ($urandom_range(0, 39) == 0);
      if (m_phase == 2) halt_cycles++;
      cycle("rand", cur_f, 1'($urandom), 1'($urandom), rmr, rrst);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
